// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber modulus and Barrett reduction constants shared by the NTT datapaths
package kyber_pkg;

   localparam int unsigned Q             = 3329;
   localparam int unsigned BARRETT_M     = 5039;
   localparam int unsigned BARRETT_SHIFT = 24;
   localparam int unsigned COEF_W        = 12;
   localparam int unsigned PROD_W        = 2 * COEF_W;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - two-stage Barrett reduction of a product below Q*Q into [0, Q)
module barrett_reduce_pipe
   import kyber_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  prod_t p,
   output coef_t r
);

   localparam int unsigned MW = PROD_W + 13;

   logic [MW-1:0] pm;
   coef_t         t_s3;
   prod_t         p_s3;
   prod_t         r_wide;
   prod_t         r_fix;

   // The quotient estimate undershoots by at most one, so a single conditional subtract finishes.
   assign pm     = MW'(p) * MW'(BARRETT_M);
   assign r_wide = p_s3 - prod_t'(t_s3 * Q);
   assign r_fix  = (r_wide >= prod_t'(Q)) ? r_wide - prod_t'(Q) : r_wide;

   // Quotient stage: estimate t = floor(p * M / 2^24) and carry p alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_s3 <= '0;
         p_s3 <= '0;
      end else if (en) begin
         t_s3 <= coef_t'(pm >> BARRETT_SHIFT);
         p_s3 <= p;
      end
   end

   // Correction stage: remainder p - t*Q folded once into [0, Q).
   always_ff @(posedge clk) begin
      if (rst) begin
         r <= '0;
      end else if (en) begin
         r <= coef_t'(r_fix);
      end
   end

endmodule

// File: rtl/gs_butterfly_pipe.sv
// rtl/gs_butterfly_pipe.sv - four-stage Gentleman-Sande butterfly for the Kyber inverse NTT
module gs_butterfly_pipe
   import kyber_pkg::*;
#(
   parameter int DW = 16,
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   input  logic [DW-1:0] in_w,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b,
   output logic [TW-1:0] out_tag
);

   logic          adv;
   logic          v1, v2, v3, v4;
   coef_t         a_c, b_c;
   logic [12:0]   sum_raw, sum_red, diff_raw, diff_fix;
   coef_t         s1_sum, s1_diff, s1_w;
   logic [TW-1:0] s1_tag;
   coef_t         s2_sum;
   prod_t         s2_p;
   logic [TW-1:0] s2_tag;
   coef_t         s3_sum;
   logic [TW-1:0] s3_tag;
   coef_t         s4_sum;
   coef_t         s4_r;
   logic [TW-1:0] s4_tag;
   logic          unused_hi;

   // Whole pipe moves together; it only freezes when a held result is not being taken.
   assign adv       = !v4 || out_ready;
   assign in_ready  = adv;
   assign out_valid = v4;
   assign out_a     = DW'(s4_sum);
   assign out_b     = DW'(s4_r);

   // Operands are 12-bit coefficients; upper bus bits carry nothing.
   assign a_c       = in_a[COEF_W-1:0];
   assign b_c       = in_b[COEF_W-1:0];
   assign unused_hi = ^{in_a[DW-1:COEF_W], in_b[DW-1:COEF_W], in_w[DW-1:COEF_W]};

   assign sum_raw  = 13'(a_c) + 13'(b_c);
   assign sum_red  = (sum_raw >= 13'(Q)) ? sum_raw - 13'(Q) : sum_raw;
   assign diff_raw = 13'(a_c) - 13'(b_c);
   assign diff_fix = diff_raw[12] ? diff_raw + 13'(Q) : diff_raw;

   // Stage valid bits; reset drops every in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
      end else if (adv) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
      end
   end

   // S1: modular sum and difference, capture twiddle and tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_sum  <= '0;
         s1_diff <= '0;
         s1_w    <= '0;
         s1_tag  <= '0;
      end else if (adv) begin
         s1_sum  <= coef_t'(sum_red);
         s1_diff <= coef_t'(diff_fix);
         s1_w    <= in_w[COEF_W-1:0];
         s1_tag  <= in_tag;
      end
   end

   // S2: full 24-bit product of difference and twiddle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sum <= '0;
         s2_p   <= '0;
         s2_tag <= '0;
      end else if (adv) begin
         s2_sum <= s1_sum;
         s2_p   <= prod_t'(s1_diff) * prod_t'(s1_w);
         s2_tag <= s1_tag;
      end
   end

   barrett_reduce_pipe u_barrett (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .p   (s2_p),
      .r   (s4_r)
   );

   // S3/S4: sum and tag delayed to line up with the reduced product.
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_sum <= '0;
         s3_tag <= '0;
         s4_sum <= '0;
         s4_tag <= '0;
      end else if (adv) begin
         s3_sum <= s2_sum;
         s3_tag <= s2_tag;
         s4_sum <= s3_sum;
         s4_tag <= s3_tag;
      end
   end

   assign out_tag = s4_tag;

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// tb/tb_gs_butterfly_pipe.sv - scoreboard bench for the Gentleman-Sande butterfly pipeline
module tb_gs_butterfly_pipe;

   localparam int Q = 3329;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic [15:0] in_w = '0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic [7:0]  out_tag;

   always #5 clk = ~clk;

   gs_butterfly_pipe #(.DW(16), .TW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_w      (in_w),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_tag   (out_tag)
   );

   typedef struct {
      int         ea;
      int         eb;
      logic [7:0] tag;
      int         cyc;
      bit         lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_from = -1;
   int          stall_to = -1;
   int          cur_ea = 0;
   int          cur_eb = 0;
   bit          cur_lat = 1'b1;
   bit          acc = 1'b0;
   bit          hold_pend = 1'b0;
   logic [15:0] h_a, h_b;
   logic [7:0]  h_tag;

   function automatic int gs_b(input int a, input int b, input int w);
      return (((a - b + Q) % Q) * w) % Q;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      out_ready = !(cyc >= stall_from && cyc < stall_to);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!rst) begin
         chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (hold_pend) begin
            chk("hold_a", 32'(out_a), 32'(h_a));
            chk("hold_b", 32'(out_b), 32'(h_b));
            chk("hold_tag", 32'(out_tag), 32'(h_tag));
         end
         if (acc)
            sb.push_back('{ea: cur_ea, eb: cur_eb, tag: in_tag, cyc: cyc, lat: cur_lat});
         if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL out_unexpected observed tag %0h expected no output", out_tag);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("out_a", 32'(out_a), 32'(e.ea));
               chk("out_b", 32'(out_b), 32'(e.eb));
               chk("out_tag", 32'(out_tag), 32'(e.tag));
               if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd4);
            end
         end
         hold_pend = out_valid && !out_ready;
         h_a       = out_a;
         h_b       = out_b;
         h_tag     = out_tag;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input int a, input int b, input int w, input logic [7:0] tag,
                       input int ea, input int eb);
      in_a     = 16'(a);
      in_b     = 16'(b);
      in_w     = 16'(w);
      in_tag   = tag;
      in_valid = 1'b1;
      cur_ea   = ea;
      cur_eb   = eb;
      acc      = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) tick();
      checks++;
      assert (acc) else begin
         errors++;
         $error("FAIL send_accept observed 0 expected 1 tag %0h", tag);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int k = 0; k < 40 && sb.size() > 0; k++) tick();
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int a, b, w, c0;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      send(5, 3, 1, 8'h01, 8, 2);
      drain();
      send(3, 5, 1, 8'h02, 8, 3327);
      drain();
      send(3328, 3328, 3328, 8'h03, 3327, 0);
      send(0, 1, 3328, 8'h04, 1, 1);
      drain();
      send(3000, 1000, 17, 8'h05, 671, 710);
      drain();

      c0 = cyc;
      for (int i = 0; i < 64; i++) begin
         a = int'($urandom_range(Q - 1));
         b = int'($urandom_range(Q - 1));
         w = int'($urandom_range(Q - 1));
         send(a, b, w, 8'(8'h40 + i), (a + b) % Q, gs_b(a, b, w));
      end
      chk("stream_cycles", 32'(cyc - c0), 32'd64);
      drain();

      cur_lat    = 1'b0;
      stall_from = cyc + 5;
      stall_to   = cyc + 8;
      for (int i = 0; i < 6; i++) begin
         a = int'($urandom_range(Q - 1));
         b = int'($urandom_range(Q - 1));
         w = int'($urandom_range(Q - 1));
         send(a, b, w, 8'(8'hA0 + i), (a + b) % Q, gs_b(a, b, w));
      end
      drain();
      cur_lat = 1'b1;

      send(100, 200, 300, 8'hE0, 300, gs_b(100, 200, 300));
      send(1, 2, 3, 8'hE1, 3, gs_b(1, 2, 3));
      send(7, 9, 11, 8'hE2, 16, gs_b(7, 9, 11));
      rst        = 1'b1;
      stall_from = cyc;
      stall_to   = cyc + 1;
      tick();
      rst = 1'b0;
      sb.delete();
      hold_pend = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      send(3000, 1000, 17, 8'h55, 671, 710);
      drain();
      for (int k = 0; k < 8; k++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
